// File: rtl/lut_neuron_table_loader.sv
// Runtime-loadable LUT neuron: streams a truth table in over a valid/ready port, then serves
// registered lookups. Optional load parity check enabled by defining LUT_LOAD_PARITY_EN.
module lut_neuron_table_loader #(
    parameter int unsigned IN_BITS  = 8,
    parameter int unsigned OUT_BITS = 1,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [WORD_W-1:0]   cfg_data,
`ifdef LUT_LOAD_PARITY_EN
    input  logic                cfg_parity,
`endif
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  M0,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] M1
);

    localparam int unsigned Depth  = 2 ** IN_BITS;
    localparam int unsigned TBits  = Depth * OUT_BITS;
    localparam int unsigned NWORDS = TBits / WORD_W;
    localparam int unsigned CntW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned IdxW   = (TBits > 1) ? $clog2(TBits) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     word_cnt_q, word_cnt_d;
    logic                done_q, done_d;
    logic [TBits-1:0]    table_q;
    logic                out_valid_q;
    logic [OUT_BITS-1:0] m1_q;
    logic                accept;
    logic                last_word;
    logic                par_ok;
    logic                lookup;
    logic [IdxW-1:0]     wr_base;
    logic [IdxW-1:0]     rd_base;

    assign cfg_ready = (state_q == StLoad);
    // A start in the same cycle as a word discards that word.
    assign accept    = cfg_valid & cfg_ready & ~cfg_start;
    assign last_word = (word_cnt_q == CntW'(NWORDS - 1));
    assign lookup    = in_valid & (state_q == StReady);
    assign wr_base   = IdxW'(word_cnt_q) * IdxW'(WORD_W);
    assign rd_base   = IdxW'(M0) * IdxW'(OUT_BITS);

`ifdef LUT_LOAD_PARITY_EN
    logic err_q, err_d;
    assign par_ok  = ~(^{cfg_parity, cfg_data});
    assign cfg_err = err_q;
`else
    assign par_ok  = 1'b1;
    assign cfg_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        done_d     = 1'b0;
`ifdef LUT_LOAD_PARITY_EN
        err_d      = err_q;
`endif
        if (cfg_start) begin
            state_d    = StLoad;
            word_cnt_d = '0;
`ifdef LUT_LOAD_PARITY_EN
            err_d      = 1'b0;
`endif
        end else if (accept) begin
            if (!par_ok) begin
                state_d    = StIdle;
                word_cnt_d = '0;
`ifdef LUT_LOAD_PARITY_EN
                err_d      = 1'b1;
`endif
            end else if (last_word) begin
                state_d    = StReady;
                word_cnt_d = '0;
                done_d     = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            m1_q        <= '0;
`ifdef LUT_LOAD_PARITY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            done_q      <= done_d;
            out_valid_q <= lookup;
            if (lookup) begin
                m1_q <= table_q[rd_base +: OUT_BITS];
            end
`ifdef LUT_LOAD_PARITY_EN
            err_q       <= err_d;
`endif
        end
    end

    // Table storage is deliberately not reset so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            table_q[wr_base +: WORD_W] <= cfg_data;
        end
    end

    assign cfg_done  = done_q;
    assign out_valid = out_valid_q;
    assign M1        = m1_q;

endmodule
